// File: rtl/ipq_pkg.sv
// rtl/ipq_pkg.sv - shared constants and types for the instruction prefetch queue
package ipq_pkg;

  // Fetch stride in bytes; every instruction is one 32-bit word.
  localparam int INSTR_BYTES = 4;

  // Default address and instruction widths used by the top-level parameters.
  localparam int IPQ_ADDR_W = 32;
  localparam int IPQ_DATA_W = 32;

  // RUN: every response belongs to the current stream.
  // DRAIN: responses for requests issued before a redirect are still in flight and get dropped.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } ipq_state_e;

  // Queue entry layout at the default widths: PC in the upper field, instruction below it.
  typedef struct packed {
    logic [IPQ_ADDR_W-1:0] pc;
    logic [IPQ_DATA_W-1:0] instr;
  } ipq_entry_t;

endpackage

// File: rtl/ipq_fifo.sv
// rtl/ipq_fifo.sv - synchronous FIFO with push, pop, flush and occupancy count
module ipq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Next state: pop only when non-empty, push into a full FIFO only alongside a pop, flush empties everything.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage and pointer registers; storage is cleared so the head never reads as unknown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - in-order instruction fetch queue with redirect flush; optional IPQ_BYPASS_EN empty-queue bypass
module instr_prefetch_queue
  import ipq_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = IPQ_ADDR_W,
  parameter int                DATA_W   = IPQ_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  // Same field order as ipq_entry_t, sized to this instance.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  ipq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]     q_count, trk_count;
  entry_t            q_head, q_push_entry;
  logic [ADDR_W-1:0] trk_head;
  logic              q_push, q_pop, trk_pop;
  logic              req_fire, rsp_live, drop_rsp, bypass_fire, q_nonempty;

  // Request side: queue plus in-flight requests stay within DEPTH; no issue during reset or a redirect.
  always_comb begin
    imem_req_valid = !reset && !redirect_valid &&
                     (({1'b0, q_count} + {1'b0, outstanding_q}) < SW'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_live       = imem_rsp_valid && (outstanding_q != '0);
  end

`ifdef IPQ_BYPASS_EN
  // A current-stream response skips the empty queue when the decoder can take it right now.
  assign bypass_fire = rsp_live && !drop_rsp && !redirect_valid && !reset &&
                       (q_count == '0) && out_ready && (trk_count != '0);
`else
  assign bypass_fire = 1'b0;
`endif

  // Fetch PC, in-flight accounting and response routing; a redirect overrides all but reset.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_live);
    drop_cnt_d    = drop_cnt_q;
    q_push        = 1'b0;
    trk_pop       = 1'b0;
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the abandoned stream.
      fetch_pc_d = redirect_pc;
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
      end
      if (rsp_live) begin
        if (drop_rsp) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else if (trk_count != '0) begin
          trk_pop = 1'b1;
          q_push  = !bypass_fire;
        end
      end
    end
  end

  // Fetch PC and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: DRAIN for as long as stale responses remain to be discarded.
  always_comb begin
    state_d = (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
  end

  // FSM outputs: responses arriving while draining are stale.
  always_comb begin
    drop_rsp = (state_q == ST_DRAIN);
  end

  // Decoder side: queue head first, bypass only when empty, idle outputs read as zero.
  always_comb begin
    q_nonempty = (q_count != '0);
    out_valid  = q_nonempty || bypass_fire;
    out_instr  = '0;
    out_pc     = '0;
    if (q_nonempty) begin
      out_instr = q_head.instr;
      out_pc    = q_head.pc;
    end else if (bypass_fire) begin
      out_instr = imem_rsp_data;
      out_pc    = trk_head;
    end
    q_pop = q_nonempty && out_ready;
  end

  assign q_push_entry = '{pc: trk_head, instr: imem_rsp_data};

  ipq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_data_q (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_push_entry),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head_data (q_head),
    .count     (q_count)
  );

  // Tracks the PC of every current-stream request still waiting for its response.
  ipq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W)
  ) u_pc_trk (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (trk_pop),
    .flush     (redirect_valid),
    .head_data (trk_head),
    .count     (trk_count)
  );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - directed self-checking bench for instr_prefetch_queue
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_prefetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // Instruction memory: fixed latency, in order; word at addr holds 0x2002_0000 | (addr >> 2).
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t pend[$];
  int   cyc = 0;
  int   lat = 2;
  int   hs_count = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (reset) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
    end else if (pend.size() > 0 && pend[0].due == cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h2002_0000 | (pend[0].addr >> 2);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset && imem_req_valid && imem_req_ready) begin
      pend.push_back('{imem_req_addr, cyc + 1 + lat});
      hs_count = hs_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic restart(input int l, input logic rdy);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = rdy;
    lat            = l;
    step(2);
    reset = 1'b0;
  endtask

  int base;

  initial begin
    // Reset values
    step(1);
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);

    // 1: 2-cycle memory, decoder always ready -> sequential PCs
    lat = 2; out_ready = 1'b1; reset = 1'b0;
    step(1);
    check("t1_valid_a1", 32'(out_valid), 32'h0);
    check("t1_addr_a1", imem_req_addr, 32'h4);
    step(1);
    check("t1_valid_a2", 32'(out_valid), 32'h0);
    step(1);
    check("t1_valid_a3", 32'(out_valid), 32'h1);
    check("t1_pc0", out_pc, 32'h0);
    check("t1_instr0", out_instr, 32'h2002_0000);
    step(1);
    check("t1_pc1", out_pc, 32'h4);
    check("t1_instr1", out_instr, 32'h2002_0001);
    step(1);
    check("t1_pc2", out_pc, 32'h8);
    check("t1_instr2", out_instr, 32'h2002_0002);
    step(1);
    check("t1_pc3", out_pc, 32'hC);
    check("t1_instr3", out_instr, 32'h2002_0003);

    // 2: decoder stalled -> exactly DEPTH requests, then issue stops until a pop
    restart(2, 1'b0);
    base = hs_count;
    step(10);
    check("t2_hs_count", 32'(hs_count - base), 32'd4);
    check("t2_req_valid_full", 32'(imem_req_valid), 32'h0);
    check("t2_out_valid", 32'(out_valid), 32'h1);
    check("t2_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("t2_req_valid_after_pop", 32'(imem_req_valid), 32'h1);
    check("t2_head_pc_after_pop", out_pc, 32'h4);
    check("t2_req_addr", imem_req_addr, 32'h10);

    // 3: redirect with two requests outstanding -> both stale responses dropped
    restart(3, 1'b1);
    step(2);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    check("t3_req_valid_redirect", 32'(imem_req_valid), 32'h0);
    step(1);
    redirect_valid = 1'b0;
    check("t3_req_addr", imem_req_addr, 32'h100);
    check("t3_valid_a3", 32'(out_valid), 32'h0);
    step(1);
    check("t3_valid_a4", 32'(out_valid), 32'h0);
    step(1);
    check("t3_valid_a5", 32'(out_valid), 32'h0);
    step(1);
    check("t3_valid_a6", 32'(out_valid), 32'h0);
    step(1);
    check("t3_valid_a7", 32'(out_valid), 32'h1);
    check("t3_pc", out_pc, 32'h100);
    check("t3_instr", out_instr, 32'h2002_0040);

    // 4: redirect in the same cycle as a pop and a response
    restart(2, 1'b1);
    step(3);
    check("t4_pre_valid", 32'(out_valid), 32'h1);
    check("t4_pre_pc", out_pc, 32'h0);
    check("t4_pre_rsp", 32'(imem_rsp_valid), 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step(1);
    redirect_valid = 1'b0;
    check("t4_flushed", 32'(out_valid), 32'h0);
    #1;
    check("t4_req_valid", 32'(imem_req_valid), 32'h1);
    check("t4_req_addr", imem_req_addr, 32'h200);
    step(1);
    check("t4_valid_a5", 32'(out_valid), 32'h0);
    step(1);
    check("t4_valid_a6", 32'(out_valid), 32'h0);
    step(1);
    check("t4_valid_a7", 32'(out_valid), 32'h1);
    check("t4_pc", out_pc, 32'h200);
    check("t4_instr", out_instr, 32'h2002_0080);

    // 5: reset with three requests outstanding
    restart(3, 1'b1);
    step(3);
    reset = 1'b1;
    step(1);
    check("t5_req_valid", 32'(imem_req_valid), 32'h0);
    check("t5_req_addr", imem_req_addr, 32'h0);
    check("t5_out_valid", 32'(out_valid), 32'h0);
    check("t5_out_instr", out_instr, 32'h0);
    check("t5_out_pc", out_pc, 32'h0);
    reset = 1'b0;
    #1;
    check("t5_restart_valid", 32'(imem_req_valid), 32'h1);
    check("t5_restart_addr", imem_req_addr, 32'h0);
    step(1);
    check("t5_addr_next", imem_req_addr, 32'h4);
    step(1);
    check("t5_valid_a6", 32'(out_valid), 32'h0);
    step(1);
    check("t5_valid_a7", 32'(out_valid), 32'h0);
    step(1);
    check("t5_pc", out_pc, 32'h0);
    check("t5_instr", out_instr, 32'h2002_0000);

    // 6: response 0x2002_0005 into an empty queue with the decoder ready
    restart(2, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h14;
    step(1);
    redirect_valid = 1'b0;
    step(2);
    check("t6_rsp_data", imem_rsp_data, 32'h2002_0005);
`ifdef IPQ_BYPASS_EN
    check("t6_bypass_valid", 32'(out_valid), 32'h1);
    check("t6_bypass_pc", out_pc, 32'h14);
    check("t6_bypass_instr", out_instr, 32'h2002_0005);
`else
    check("t6_no_bypass_valid", 32'(out_valid), 32'h0);
    step(1);
    check("t6_valid", 32'(out_valid), 32'h1);
    check("t6_pc", out_pc, 32'h14);
    check("t6_instr", out_instr, 32'h2002_0005);
`endif

    // 7: fetch PC wraps past the top of the address space
    restart(2, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    #1;
    check("t7_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    step(1);
    check("t7_addr_wrap", imem_req_addr, 32'h0);
    step(2);
    check("t7_pc", out_pc, 32'hFFFF_FFFC);
    check("t7_instr", out_instr, 32'h3FFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
